// File: rtl/otter_fetch_stage.sv
// OTTER IF stage: owns the PC and issues one outstanding word fetch at a time to a variable-latency instruction memory.
// Latency: F outputs register one edge after imem_rvalid; zero-wait memory sustains 1 instr/cycle.
// Backpressure: stall_F holds the F outputs; a response arriving under stall parks in a one-entry skid buffer and fetching pauses.
module otter_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        stall_F,
    input  logic        redirect_E,
    input  logic [31:0] redirect_pc_E,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr_F,
    output logic [31:0] PC_F,
    output logic [31:0] PC_plus4_F,
    output logic        valid_F
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_KILL = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] kill_addr_q;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc_f_q;
    logic [31:0] pc_plus4_f_q;
    logic        valid_f_q;

    // Word-aligned redirect target and sequential next PC.
    logic [31:0] redirect_tgt_d;
    logic [31:0] pc_inc_d;

    assign redirect_tgt_d = redirect_pc_E & ~32'h0000_0003;
    assign pc_inc_d       = pc_q + 32'd4;

    // Request is gated by reset so it drops immediately on RST_N; KILL keeps the squashed address on the bus.
    assign imem_req  = RST_N && (state_q != ST_HOLD);
    assign imem_addr = (state_q == ST_KILL) ? kill_addr_q : pc_q;

    assign Instr_F    = instr_q;
    assign PC_F       = pc_f_q;
    assign PC_plus4_F = pc_plus4_f_q;
    assign valid_F    = valid_f_q;

    // Fetch FSM, PC, skid buffer and registered F outputs; redirect overrides stall and every other event.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            kill_addr_q  <= 32'h0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            instr_q      <= NOP_INSTR;
            pc_f_q       <= 32'h0;
            pc_plus4_f_q <= 32'h0;
            valid_f_q    <= 1'b0;
        end else if (redirect_E) begin
            // Bubble out, drop whatever is buffered, and restart at the target.
            instr_q   <= NOP_INSTR;
            valid_f_q <= 1'b0;
            pc_q      <= redirect_tgt_d;
            case (state_q)
                ST_REQ: begin
                    if (imem_rvalid) begin
                        state_q <= ST_REQ;
                    end else begin
                        // Request still in flight: wait out its response on the same address.
                        kill_addr_q <= pc_q;
                        state_q     <= ST_KILL;
                    end
                end
                ST_HOLD: state_q <= ST_REQ;
                ST_KILL: state_q <= imem_rvalid ? ST_REQ : ST_KILL;
                default: state_q <= ST_REQ;
            endcase
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (imem_rvalid) begin
                        pc_q <= pc_inc_d;
                        if (stall_F) begin
                            skid_instr_q <= imem_rdata;
                            skid_pc_q    <= pc_q;
                            state_q      <= ST_HOLD;
                        end else begin
                            instr_q      <= imem_rdata;
                            pc_f_q       <= pc_q;
                            pc_plus4_f_q <= pc_inc_d;
                            valid_f_q    <= 1'b1;
                        end
                    end else if (!stall_F) begin
                        instr_q   <= NOP_INSTR;
                        valid_f_q <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall_F) begin
                        instr_q      <= skid_instr_q;
                        pc_f_q       <= skid_pc_q;
                        pc_plus4_f_q <= skid_pc_q + 32'd4;
                        valid_f_q    <= 1'b1;
                        state_q      <= ST_REQ;
                    end
                end
                ST_KILL: begin
                    // Wrong-path data is discarded; the correct PC is already in pc_q.
                    if (!stall_F) begin
                        instr_q   <= NOP_INSTR;
                        valid_f_q <= 1'b0;
                    end
                    if (imem_rvalid) begin
                        state_q <= ST_REQ;
                    end
                end
                default: state_q <= ST_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Self-checking bench for otter_fetch_stage: directed vector table, mid-wait reset, then randomized run against a program-order model.
// Latency: checks outputs 1 time unit after each rising edge and bus signals just before it.
// Backpressure: bench drives stall_F and the memory response; the memory model honours the one-outstanding protocol.
module tb_otter_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK;
    logic        RST_N;
    logic        stall_F;
    logic        redirect_E;
    logic [31:0] redirect_pc_E;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instr_F;
    logic [31:0] PC_F;
    logic [31:0] PC_plus4_F;
    logic        valid_F;

    int errors = 0;
    int checks = 0;

    otter_fetch_stage dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .stall_F      (stall_F),
        .redirect_E   (redirect_E),
        .redirect_pc_E(redirect_pc_E),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .Instr_F      (Instr_F),
        .PC_F         (PC_F),
        .PC_plus4_F   (PC_plus4_F),
        .valid_F      (valid_F)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Instruction memory contents: a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) + 32'h1234_5679;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        rvld;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evld;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic r, input logic [31:0] rpc, input logic rv,
                       input logic ereq, input logic [31:0] eaddr, input logic evld, input logic [31:0] epc);
        vec_t v;
        v.stall = s; v.redir = r; v.rpc = rpc; v.rvld = rv;
        v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.epc = epc;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        stall_F = 1'b0; redirect_E = 1'b0; redirect_pc_E = 32'h0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        // Randomized-phase state
        logic [31:0] exp_pc;
        logic [31:0] p_instr, p_pc, p_p4;
        logic        p_vld;
        logic        prev_req, prev_rvld;
        logic [31:0] prev_addr;
        int          wcnt, lat, ninstr;
        logic        s, r, rv, req_now;
        logic [31:0] rpc;

        RST_N = 1'b0;
        stall_F = 1'b0; redirect_E = 1'b0; redirect_pc_E = 32'h0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;

        // ---------------- Directed vector table ----------------
        //   stall redir target        rvld  req  addr          vld  PC_F
        add(0, 0, 32'h0,          1,   1, 32'h0000,     1, 32'h0000);
        add(0, 0, 32'h0,          1,   1, 32'h0004,     1, 32'h0004);
        add(0, 0, 32'h0,          1,   1, 32'h0008,     1, 32'h0008);
        add(0, 1, 32'h10,         1,   1, 32'h000C,     0, 32'h0008);
        add(0, 0, 32'h0,          0,   1, 32'h0010,     0, 32'h0008);
        add(0, 0, 32'h0,          1,   1, 32'h0010,     1, 32'h0010);
        add(0, 0, 32'h0,          1,   1, 32'h0014,     1, 32'h0014);
        add(0, 0, 32'h0,          1,   1, 32'h0018,     1, 32'h0018);
        add(0, 0, 32'h0,          1,   1, 32'h001C,     1, 32'h001C);
        add(1, 0, 32'h0,          1,   1, 32'h0020,     1, 32'h001C);
        add(1, 0, 32'h0,          0,   0, 32'h0,        1, 32'h001C);
        add(1, 0, 32'h0,          0,   0, 32'h0,        1, 32'h001C);
        add(0, 0, 32'h0,          0,   0, 32'h0,        1, 32'h0020);
        add(0, 0, 32'h0,          1,   1, 32'h0024,     1, 32'h0024);
        add(0, 1, 32'h40,         1,   1, 32'h0028,     0, 32'h0024);
        add(0, 0, 32'h0,          0,   1, 32'h0040,     0, 32'h0024);
        add(0, 1, 32'h100,        0,   1, 32'h0040,     0, 32'h0024);
        add(0, 0, 32'h0,          0,   1, 32'h0040,     0, 32'h0024);
        add(0, 0, 32'h0,          1,   1, 32'h0040,     0, 32'h0024);
        add(0, 0, 32'h0,          0,   1, 32'h0100,     0, 32'h0024);
        add(0, 0, 32'h0,          1,   1, 32'h0100,     1, 32'h0100);
        add(1, 1, 32'h203,        1,   1, 32'h0104,     0, 32'h0100);
        add(0, 0, 32'h0,          1,   1, 32'h0200,     1, 32'h0200);
        add(0, 1, 32'h300,        0,   1, 32'h0204,     0, 32'h0200);
        add(0, 1, 32'h400,        0,   1, 32'h0204,     0, 32'h0200);
        add(0, 0, 32'h0,          1,   1, 32'h0204,     0, 32'h0200);
        add(0, 0, 32'h0,          1,   1, 32'h0400,     1, 32'h0400);
        add(1, 0, 32'h0,          1,   1, 32'h0404,     1, 32'h0400);
        add(1, 1, 32'h500,        0,   0, 32'h0,        0, 32'h0400);
        add(0, 0, 32'h0,          1,   1, 32'h0500,     1, 32'h0500);
        add(0, 1, 32'hFFFF_FFFC,  1,   1, 32'h0504,     0, 32'h0500);
        add(0, 0, 32'h0,          1,   1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC);
        add(0, 0, 32'h0,          1,   1, 32'h0000,     1, 32'h0000);

        // Reset state
        repeat (2) @(negedge CLK);
        #1;
        chk("reset imem_req", {31'h0, imem_req}, 32'h0);
        chk("reset valid_F", {31'h0, valid_F}, 32'h0);
        chk("reset Instr_F", Instr_F, NOP);
        chk("reset PC_F", PC_F, 32'h0);
        chk("reset PC_plus4_F", PC_plus4_F, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            stall_F       = vecs[i].stall;
            redirect_E    = vecs[i].redir;
            redirect_pc_E = vecs[i].rpc;
            imem_rvalid   = vecs[i].rvld;
            imem_rdata    = vecs[i].rvld ? mem_word(imem_addr) : $urandom;
            #1;
            chk($sformatf("vec%0d imem_req", i), {31'h0, imem_req}, {31'h0, vecs[i].ereq});
            if (vecs[i].ereq)
                chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].eaddr);
            @(posedge CLK);
            #1;
            chk($sformatf("vec%0d valid_F", i), {31'h0, valid_F}, {31'h0, vecs[i].evld});
            chk($sformatf("vec%0d PC_F", i), PC_F, vecs[i].epc);
            chk($sformatf("vec%0d PC_plus4_F", i), PC_plus4_F, vecs[i].epc + 32'd4);
            chk($sformatf("vec%0d Instr_F", i), Instr_F, vecs[i].evld ? mem_word(vecs[i].epc) : NOP);
            @(negedge CLK);
        end

        // ---------------- Asynchronous reset while a fetch is waiting ----------------
        stall_F = 1'b0; redirect_E = 1'b0; imem_rvalid = 1'b0;
        #1;
        chk("midwait imem_req before reset", {31'h0, imem_req}, 32'h1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async reset imem_req", {31'h0, imem_req}, 32'h0);
        chk("async reset valid_F", {31'h0, valid_F}, 32'h0);
        chk("async reset Instr_F", Instr_F, NOP);
        chk("async reset PC_F", PC_F, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("post-reset imem_req", {31'h0, imem_req}, 32'h1);
        chk("post-reset imem_addr", imem_addr, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(32'h0);
        @(posedge CLK);
        #1;
        chk("post-reset valid_F", {31'h0, valid_F}, 32'h1);
        chk("post-reset PC_F", PC_F, 32'h0);
        chk("post-reset Instr_F", Instr_F, mem_word(32'h0));

        // ---------------- Randomized run vs program-order model ----------------
        do_reset();
        exp_pc = 32'h0;
        p_instr = NOP; p_pc = 32'h0; p_p4 = 32'h0; p_vld = 1'b0;
        prev_req = 1'b0; prev_rvld = 1'b0; prev_addr = 32'h0;
        wcnt = 0; lat = $urandom_range(0, 3); ninstr = 0;

        for (int c = 0; c < 3000; c++) begin
            // An unanswered request must keep its address on the bus.
            if (prev_req && !prev_rvld && imem_req)
                chk($sformatf("cyc%0d imem_addr stable", c), imem_addr, prev_addr);

            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 19) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0)
                rpc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            rv = imem_req && (wcnt >= lat);
            req_now = imem_req;

            stall_F       = s;
            redirect_E    = r;
            redirect_pc_E = rpc;
            imem_rvalid   = rv;
            imem_rdata    = rv ? mem_word(imem_addr) : $urandom;
            prev_req  = imem_req;
            prev_rvld = rv;
            prev_addr = imem_addr;

            @(posedge CLK);
            #1;
            if (r) begin
                chk($sformatf("cyc%0d redirect valid_F", c), {31'h0, valid_F}, 32'h0);
                chk($sformatf("cyc%0d redirect Instr_F", c), Instr_F, NOP);
                exp_pc = rpc & ~32'h3;
            end else if (s) begin
                chk($sformatf("cyc%0d stall Instr_F", c), Instr_F, p_instr);
                chk($sformatf("cyc%0d stall PC_F", c), PC_F, p_pc);
                chk($sformatf("cyc%0d stall valid_F", c), {31'h0, valid_F}, {31'h0, p_vld});
            end else if (valid_F) begin
                chk($sformatf("cyc%0d PC_F order", c), PC_F, exp_pc);
                chk($sformatf("cyc%0d Instr_F", c), Instr_F, mem_word(exp_pc));
                chk($sformatf("cyc%0d PC_plus4_F", c), PC_plus4_F, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                ninstr++;
            end else begin
                chk($sformatf("cyc%0d bubble Instr_F", c), Instr_F, NOP);
                chk($sformatf("cyc%0d bubble PC_F", c), PC_F, p_pc);
                chk($sformatf("cyc%0d bubble PC_plus4_F", c), PC_plus4_F, p_p4);
            end
            p_instr = Instr_F; p_pc = PC_F; p_p4 = PC_plus4_F; p_vld = valid_F;

            // Memory latency bookkeeping for the next request.
            if (req_now && rv) begin
                wcnt = 0;
                lat  = $urandom_range(0, 3);
            end else if (req_now) begin
                wcnt++;
            end
            @(negedge CLK);
        end
        chk("random run made progress", {31'h0, (ninstr > 200)}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/otter_fetch_stage.md
Name: otter_fetch_stage

Overview:
- IF stage of the OTTER pipelined MCU. Owns the PC register and issues word fetches to a variable-latency instruction memory, one request outstanding at a time.
- Presents Instr_F, PC_F and PC_plus4_F, with a valid flag, to the fetch/decode pipeline register.
- Absorbs decode stalls with a one-entry skid buffer.
- Takes branch/jump redirects from execute and squashes wrong-path fetches, including any in-flight memory response.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, instruction presented on bubbles (addi x0,x0,0).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  reset.
- stall_F  input  1  downstream cannot accept; hold the F outputs.
- redirect_E  input  1  taken branch/jump in execute; flush and refetch.
- redirect_pc_E  input  32  redirect target; bits [1:0] ignored (forced 0).
- imem_req  output  1  fetch request; held high until imem_rvalid.
- imem_addr  output  32  fetch word address; stable while imem_req=1 and no imem_rvalid yet.
- imem_rvalid  input  1  response valid. May assert in the same cycle as imem_req (zero-wait) or any later cycle.
- imem_rdata  input  32  fetched instruction, valid with imem_rvalid.
- Instr_F  output  32  instruction to the decode register.
- PC_F  output  32  address of Instr_F.
- PC_plus4_F  output  32  PC_F+4.
- valid_F  output  1  Instr_F is a real instruction (0 = bubble).

Behaviour:
- Clocking and reset: one clock, CLK. Reset RST_N is asynchronous, active-low.
- Reset values:
  - state=REQ, pc_q=RESET_PC, imem_req=0 while RST_N=0.
  - Instr_F=NOP_INSTR, PC_F=0, PC_plus4_F=0, valid_F=0.
  - Skid buffer empty.
  - First request (addr RESET_PC) asserts the first cycle after RST_N rises.
- Registered outputs: F outputs change only on a clock edge. They never change while stall_F=1, except on a redirect.
- State REQ:
  - imem_req=1, imem_addr=pc_q.
  - On imem_rvalid with stall_F=0: Instr_F<=rdata, PC_F<=pc_q, PC_plus4_F<=pc_q+4, valid_F<=1, pc_q<=pc_q+4; stay REQ. Throughput is 1 instr/cycle with zero-wait memory.
  - On imem_rvalid with stall_F=1: capture {rdata,pc_q} into the skid buffer, pc_q<=pc_q+4, go HOLD.
  - No imem_rvalid and stall_F=0: F outputs <= bubble (NOP_INSTR, valid_F=0, PC_F/PC_plus4_F unchanged).
- State HOLD:
  - imem_req=0.
  - When stall_F=0: F outputs <= buffer (valid_F=1), buffer cleared, go REQ.
- State KILL:
  - imem_req=1, imem_addr=kill_addr_q, the squashed request's address, held stable.
  - On imem_rvalid: discard the data, go REQ at pc_q.
  - F outputs stay bubble while stall_F=0.
- Redirect (redirect_E=1) has priority over stall_F and all other events:
  - F outputs <= bubble (NOP_INSTR, valid_F=0).
  - Skid buffer dropped.
  - pc_q <= {redirect_pc_E[31:2],2'b00}.
- Redirect next state:
  - From REQ with no imem_rvalid this cycle: kill_addr_q<=pc_q, go KILL.
  - From REQ with imem_rvalid this cycle: response discarded, go REQ.
  - From HOLD: go REQ.
  - From KILL without imem_rvalid: stay KILL, kill_addr_q unchanged, pc_q takes the newest target.
  - From KILL with imem_rvalid: go REQ.
- Wrong-path response: a response belonging to a squashed request never reaches the F outputs.
- Arithmetic: PC adds are 32-bit modulo 2^32. pc_q=32'hFFFF_FFFC wraps to 0; PC_plus4_F=0 in that case.
- Reset mid-operation: all state returns to reset values immediately, regardless of any outstanding request. The instruction memory shares RST_N and drops its outstanding response.
- Illegal state encodings recover to REQ.

Test Plan:
- Zero-wait memory, rvalid=req, no stalls, RESET_PC=0 -> F outputs 0x0,0x4,0x8,... on consecutive cycles, valid_F=1 from the second cycle after reset release.
- 2-cycle memory latency -> imem_addr stable 0x10 for 2 cycles. Instr_F=rdata, PC_F=0x10, PC_plus4_F=0x14 one edge after rvalid. Bubble (valid_F=0, Instr_F=0x13) during waits.
- stall_F=1 for 3 cycles while rvalid returns addr 0x20 -> imem_req drops, outputs hold the previous instruction. After stall_F falls, PC_F=0x20 next edge, then a fetch of 0x24. No instruction is lost or duplicated.
- redirect_E=1, target 0x100, while a request to 0x40 is outstanding -> KILL holds imem_addr=0x40. The 0x40 data is discarded. Next request is 0x100. valid_F=0 until 0x100 returns.
- Redirect coincident with rvalid and stall_F=1, target 0x203 -> data dropped, bubble output, next imem_addr=0x200.
- Wrap, plus reset: fetch at 0xFFFF_FFFC -> PC_plus4_F=0, next imem_addr=0. Assert RST_N=0 mid-wait -> imem_req=0 and valid_F=0 immediately (asynchronous), refetch from RESET_PC after release.
